// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter: one-hot rotating pointer picks the next owner; the grant is held until done, request drop or hold limit.
// Grant appears 1 edge after request; one idle cycle separates consecutive grants.
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 timeout,
    output logic [N-1:0]         ptr
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]    state;
    logic [HW-1:0] hcnt;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic          owner_release;
    logic          limit_hit;

    // Scan requests starting at the pointer position, wrapping around the ring.
    always_comb begin
        int pidx;
        int idx;
        pidx      = 0;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) pidx = i;
        end
        for (int k = 0; k < N; k++) begin
            idx = (pidx + k) % N;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    assign owner_release = done[grant_id] || !req[grant_id];
    assign limit_hit     = (hcnt == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= N'(1);
            gnt      <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hcnt     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt      <= N'(1) << win_idx;
                        grant_id <= win_idx;
                        busy     <= 1'b1;
                        hcnt     <= '0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (owner_release || limit_hit) begin
                        timeout  <= !owner_release;
                        ptr      <= {gnt[N-2:0], gnt[N-1]};
                        gnt      <= '0;
                        grant_id <= '0;
                        busy     <= 1'b0;
                        hcnt     <= '0;
                        state    <= IDLE;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Randomised and directed bench for ring_rr_arbiter against an integer-level owner/ring model.
module tb_ring_rr_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;
    logic [N-1:0] ptr;

    int errors = 0;
    int checks = 0;

    // model: owner index (-1 idle), cycles held so far, pointer index, timeout flag
    int m_own = -1;
    int m_cnt = 0;
    int m_ptr = 0;
    bit m_to  = 1'b0;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .gnt(gnt),
        .grant_id(grant_id), .busy(busy), .timeout(timeout), .ptr(ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1;
        m_cnt = 0;
        m_ptr = 0;
        m_to  = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
        bit rel;
        m_to = 1'b0;
        if (m_own < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_own < 0 && r[(m_ptr + k) % N]) begin
                    m_own = (m_ptr + k) % N;
                    m_cnt = 1;
                end
            end
        end else begin
            rel = 1'b0;
            if (d[m_own] || !r[m_own]) rel = 1'b1;
            else if (m_cnt == MAX_HOLD) begin
                rel  = 1'b1;
                m_to = 1'b1;
            end else m_cnt++;
            if (rel) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end
        end
    endtask

    task automatic compare_model();
        check("gnt", 32'(gnt), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
        check("grant_id", 32'(grant_id), (m_own < 0) ? 32'd0 : 32'(m_own));
        check("busy", 32'(busy), (m_own < 0) ? 32'd0 : 32'd1);
        check("timeout", 32'(timeout), 32'(m_to));
        check("ptr", 32'(ptr), 32'd1 << m_ptr);
    endtask

    // drive at the falling edge, clock once, then compare at the next falling edge
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        int order[$];
        int hi;
        logic [N-1:0] prev_gnt;
        logic [N-1:0] d;

        rst  = 1'b1;
        req  = '0;
        done = '0;
        #12;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_ptr", 32'(ptr), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        compare_model();

        // single requester finishing via done after 3 granted cycles
        cycle(4'b0100, 4'b0000);
        check("t2_gnt", 32'(gnt), 32'h4);
        cycle(4'b0100, 4'b0000);
        cycle(4'b0100, 4'b0000);
        cycle(4'b0100, 4'b0100);
        check("t2_rel_gnt", 32'(gnt), 32'd0);
        check("t2_ptr", 32'(ptr), 32'h8);
        check("t2_timeout", 32'(timeout), 32'd0);

        // wrap from ptr=3 to requester 0
        cycle(4'b0101, 4'b0000);
        check("t6_gnt", 32'(gnt), 32'h1);
        check("t6_id", 32'(grant_id), 32'd0);
        cycle(4'b0000, 4'b0000);

        // all requesting, each owner finishes after 2 cycles
        do_reset();
        prev_gnt = '0;
        for (int i = 0; i < 20 && order.size() < 5; i++) begin
            d = (m_own >= 0 && m_cnt == 2) ? (4'b0001 << m_own) : 4'b0000;
            cycle(4'b1111, d);
            if (prev_gnt == 0 && gnt != 0) order.push_back(int'(grant_id));
            prev_gnt = gnt;
        end
        check("t3_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check("t3_order", 32'(order[i]), 32'(i % 4));
        cycle(4'b0000, 4'b0000);

        // hold limit
        do_reset();
        cycle(4'b0010, 4'b0000);
        hi = 0;
        for (int i = 0; i < 20 && gnt != 0; i++) begin
            hi++;
            cycle(4'b0010, 4'b0000);
        end
        check("t4_high_cycles", 32'(hi), 32'(MAX_HOLD));
        check("t4_timeout", 32'(timeout), 32'd1);
        check("t4_ptr", 32'(ptr), 32'h4);
        cycle(4'b0010, 4'b0000);
        check("t4_regrant", 32'(gnt), 32'h2);
        check("t4_timeout_clr", 32'(timeout), 32'd0);

        // non-owner done ignored; owner request drop releases
        cycle(4'b1010, 4'b1000);
        check("t5_hold", 32'(gnt), 32'h2);
        cycle(4'b1000, 4'b1000);
        check("t5_rel", 32'(gnt), 32'd0);
        check("t5_ptr", 32'(ptr), 32'h4);
        check("t5_timeout", 32'(timeout), 32'd0);
        cycle(4'b0000, 4'b0000);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            cycle(N'($urandom), d);
        end

        // asynchronous reset in the middle of a grant
        for (int i = 0; i < 20 && !busy; i++) cycle(4'b1111, 4'b0000);
        check("t1_busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t1_gnt", 32'(gnt), 32'd0);
        check("t1_ptr", 32'(ptr), 32'h1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_timeout", 32'(timeout), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) cycle(N'($urandom), ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
